// File: rtl/periph_mailbox_slave_if.sv
// Bus and streaming signals for one mailbox slave slot.
// The slave modport is the peripheral side; master is the interconnect/core side.
interface periph_mailbox_slave_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  i_WEnable;
  logic [ADDR_WIDTH-1:0] i_WAddr;
  logic [DATA_WIDTH-1:0] i_WData;
  logic                  i_REnable;
  logic [ADDR_WIDTH-1:0] i_RAddr;
  logic [DATA_WIDTH-1:0] o_RData;
  logic [DATA_WIDTH-1:0] o_TxData;
  logic                  o_TxValid;
  logic                  i_TxReady;
  logic [DATA_WIDTH-1:0] i_RxData;
  logic                  i_RxValid;
  logic                  o_RxReady;
  logic                  o_Irq;

  modport slave (
    input  i_WEnable, i_WAddr, i_WData, i_REnable, i_RAddr,
    input  i_TxReady, i_RxData, i_RxValid,
    output o_RData, o_TxData, o_TxValid, o_RxReady, o_Irq
  );

  modport master (
    output i_WEnable, i_WAddr, i_WData, i_REnable, i_RAddr,
    output i_TxReady, i_RxData, i_RxValid,
    input  o_RData, o_TxData, o_TxValid, o_RxReady, o_Irq
  );
endinterface

// File: rtl/periph_mailbox_slave.sv
// Mailbox slave: CTRL/STATUS/DATA/SCRATCH/THRESH registers in front of a
// CPU-fed TX FIFO and a hardware-fed RX FIFO, with a threshold interrupt.
module periph_mailbox_slave #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int OFFSET_BITS = 3,
  parameter int FIFO_DEPTH  = 8
) (
  input logic i_Clk,
  input logic i_Rst,
  periph_mailbox_slave_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  typedef logic [OFFSET_BITS-1:0] off_t;
  localparam off_t OFF_CTRL    = off_t'(0);
  localparam off_t OFF_STATUS  = off_t'(1);
  localparam off_t OFF_DATA    = off_t'(2);
  localparam off_t OFF_SCRATCH = off_t'(3);
  localparam off_t OFF_THRESH  = off_t'(4);

  off_t woff, roff;
  logic wr_ctrl, wr_status, wr_data, wr_scratch, wr_thresh, rd_data, flush;
  logic ctrl_en, ctrl_irq_en, tx_ovf, rx_udf, irq;
  logic [DATA_WIDTH-1:0] scratch, rdata, rd_val;
  logic [7:0] thresh;

  logic [DATA_WIDTH-1:0] tx_mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] rx_mem [FIFO_DEPTH];
  logic [PW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
  logic [CW-1:0] tx_count, rx_count;
  logic tx_empty, tx_full, rx_empty, rx_full;
  logic tx_push, tx_pop, rx_push, rx_pop, rx_ready;
  logic unused_addr;

  assign unused_addr = ^{bus.i_WAddr[ADDR_WIDTH-1:OFFSET_BITS],
                         bus.i_RAddr[ADDR_WIDTH-1:OFFSET_BITS]};

  assign woff       = bus.i_WAddr[OFFSET_BITS-1:0];
  assign roff       = bus.i_RAddr[OFFSET_BITS-1:0];
  assign wr_ctrl    = bus.i_WEnable && (woff == OFF_CTRL);
  assign wr_status  = bus.i_WEnable && (woff == OFF_STATUS);
  assign wr_data    = bus.i_WEnable && (woff == OFF_DATA);
  assign wr_scratch = bus.i_WEnable && (woff == OFF_SCRATCH);
  assign wr_thresh  = bus.i_WEnable && (woff == OFF_THRESH);
  assign rd_data    = bus.i_REnable && (roff == OFF_DATA);
  assign flush      = wr_ctrl && bus.i_WData[1];

  assign tx_empty = (tx_count == '0);
  assign tx_full  = (tx_count == CW'(FIFO_DEPTH));
  assign rx_empty = (rx_count == '0);
  assign rx_full  = (rx_count == CW'(FIFO_DEPTH));

  // A full TX FIFO still takes a push when the head leaves in the same cycle.
  assign tx_pop   = ctrl_en && !tx_empty && bus.i_TxReady;
  assign tx_push  = wr_data && (!tx_full || tx_pop);
  assign rx_ready = ctrl_en && !rx_full;
  assign rx_push  = bus.i_RxValid && rx_ready;
  assign rx_pop   = rd_data && !rx_empty;

  assign bus.o_TxValid = ctrl_en && !tx_empty;
  assign bus.o_TxData  = tx_empty ? '0 : tx_mem[tx_rp];
  assign bus.o_RxReady = rx_ready;
  assign bus.o_RData   = rdata;
  assign bus.o_Irq     = irq;

  always_ff @(posedge i_Clk) begin
    if (i_Rst || flush) begin
      tx_wp <= '0; tx_rp <= '0; tx_count <= '0;
      rx_wp <= '0; rx_rp <= '0; rx_count <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + PW'(1);
      if (tx_pop)  tx_rp <= tx_rp + PW'(1);
      if (rx_push) rx_wp <= rx_wp + PW'(1);
      if (rx_pop)  rx_rp <= rx_rp + PW'(1);
      tx_count <= tx_count + CW'(tx_push) - CW'(tx_pop);
      rx_count <= rx_count + CW'(rx_push) - CW'(rx_pop);
    end
  end

  always_ff @(posedge i_Clk) begin
    if (tx_push) tx_mem[tx_wp] <= bus.i_WData;
    if (rx_push) rx_mem[rx_wp] <= bus.i_RxData;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      ctrl_en <= 1'b0; ctrl_irq_en <= 1'b0;
      scratch <= '0;   thresh <= '0;
      tx_ovf  <= 1'b0; rx_udf <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ctrl_en     <= bus.i_WData[0];
        ctrl_irq_en <= bus.i_WData[2];
      end
      if (wr_scratch) scratch <= bus.i_WData;
      if (wr_thresh)  thresh  <= bus.i_WData[7:0];
      // A new overflow/underflow event wins over a simultaneous W1C.
      if (wr_data && tx_full && !tx_pop)     tx_ovf <= 1'b1;
      else if (wr_status && bus.i_WData[4]) tx_ovf <= 1'b0;
      if (rd_data && rx_empty)               rx_udf <= 1'b1;
      else if (wr_status && bus.i_WData[5]) rx_udf <= 1'b0;
    end
  end

  always_comb begin
    rd_val = '0;
    case (roff)
      OFF_CTRL:    rd_val = DATA_WIDTH'({ctrl_irq_en, 1'b0, ctrl_en});
      OFF_STATUS:  rd_val = DATA_WIDTH'({8'd0, 8'(rx_count), 8'(tx_count), 2'b00,
                                         rx_udf, tx_ovf, rx_full, rx_empty,
                                         tx_full, tx_empty});
      OFF_DATA:    rd_val = rx_empty ? '0 : rx_mem[rx_rp];
      OFF_SCRATCH: rd_val = scratch;
      OFF_THRESH:  rd_val = DATA_WIDTH'(thresh);
      default:     rd_val = '0;
    endcase
  end

  // Output register stage: read data and interrupt level.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      rdata <= '0;
      irq   <= 1'b0;
    end else begin
      if (bus.i_REnable) rdata <= rd_val;
      irq <= ctrl_irq_en && (rx_count != '0) && (8'(rx_count) >= thresh);
    end
  end
endmodule

// File: tb/tb_periph_mailbox_slave.sv
// Directed bench for periph_mailbox_slave: register access, TX/RX FIFOs,
// overflow/underflow flags, interrupt threshold, flush and reset.
module tb_periph_mailbox_slave;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   failed = 0;
  logic [31:0] rd;

  always #5 clk = ~clk;

  periph_mailbox_slave_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  periph_mailbox_slave #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .OFFSET_BITS(3), .FIFO_DEPTH(8)
  ) dut (
    .i_Clk (clk),
    .i_Rst (rst),
    .bus   (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.i_WEnable = 1'b1; bus.i_WAddr = a; bus.i_WData = d;
    @(negedge clk);
    bus.i_WEnable = 1'b0;
  endtask

  task automatic cpu_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.i_REnable = 1'b1; bus.i_RAddr = a;
    @(negedge clk);
    bus.i_REnable = 1'b0;
    d = bus.o_RData;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_WEnable = 0; bus.i_WAddr = 0; bus.i_WData = 0;
    bus.i_REnable = 0; bus.i_RAddr = 0;
    bus.i_TxReady = 0; bus.i_RxData = 0; bus.i_RxValid = 0;
    repeat (2) @(negedge clk);
    check("rst_rdata", bus.o_RData, 0);
    check("rst_irq", {31'd0, bus.o_Irq}, 0);
    check("rst_txvalid", {31'd0, bus.o_TxValid}, 0);
    check("rst_rxready", {31'd0, bus.o_RxReady}, 0);
    rst = 1'b0;
    cpu_read(32'd1, rd); check("rst_status", rd, 32'h0000_0005);
    cpu_read(32'd0, rd); check("rst_ctrl", rd, 0);

    // Scratch, upper address bits ignored, unmapped offsets
    cpu_write(32'h1000_0003, 32'hDEAD_BEEF);
    cpu_read(32'd3, rd); check("scratch", rd, 32'hDEAD_BEEF);
    cpu_write(32'd5, 32'h1234);
    cpu_read(32'd5, rd); check("unmapped", rd, 0);

    // TX path
    cpu_write(32'd0, 32'd1);
    cpu_write(32'd2, 32'd255);
    cpu_write(32'd2, 32'd256);
    cpu_write(32'd2, 32'd257);
    cpu_read(32'd1, rd); check("tx3_status", rd, 32'h0000_0304);
    check("tx3_valid", {31'd0, bus.o_TxValid}, 1);
    check("tx3_head", bus.o_TxData, 255);
    bus.i_TxReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("tx_out%0d", i), bus.o_TxData, 32'(255 + i));
      @(negedge clk);
    end
    bus.i_TxReady = 1'b0;
    check("tx_drained_valid", {31'd0, bus.o_TxValid}, 0);
    check("tx_drained_data", bus.o_TxData, 0);
    cpu_read(32'd1, rd); check("tx_empty_status", rd, 32'h0000_0005);

    // TX overflow
    for (int i = 0; i < 8; i++) cpu_write(32'd2, 32'(10 + i));
    cpu_write(32'd2, 32'd1000);
    cpu_read(32'd1, rd); check("tx_ovf_status", rd, 32'h0000_0816);
    cpu_write(32'd1, 32'h10);
    cpu_read(32'd1, rd); check("tx_ovf_clear", rd, 32'h0000_0806);
    bus.i_TxReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("tx_full_out%0d", i), bus.o_TxData, 32'(10 + i));
      @(negedge clk);
    end
    check("tx_1000_absent", {31'd0, bus.o_TxValid}, 0);
    bus.i_TxReady = 1'b0;

    // RX path and underflow
    @(negedge clk);
    check("rx_ready", {31'd0, bus.o_RxReady}, 1);
    bus.i_RxValid = 1'b1; bus.i_RxData = 32'd127;
    @(negedge clk);
    bus.i_RxData = 32'd128;
    @(negedge clk);
    bus.i_RxValid = 1'b0;
    cpu_read(32'd2, rd); check("rx_pop0", rd, 127);
    @(negedge clk);
    check("rdata_held", bus.o_RData, 127);
    cpu_read(32'd2, rd); check("rx_pop1", rd, 128);
    cpu_read(32'd2, rd); check("rx_udf_data", rd, 0);
    cpu_read(32'd1, rd); check("rx_udf_status", rd, 32'h0000_0025);
    cpu_write(32'd1, 32'h20);
    cpu_read(32'd1, rd); check("rx_udf_clear", rd, 32'h0000_0005);

    // Interrupt threshold
    cpu_write(32'd4, 32'd2);
    cpu_write(32'd0, 32'd5);
    @(negedge clk);
    bus.i_RxValid = 1'b1; bus.i_RxData = 32'd77;
    @(negedge clk);
    bus.i_RxValid = 1'b0;
    repeat (2) @(negedge clk);
    check("irq_below", {31'd0, bus.o_Irq}, 0);
    bus.i_RxValid = 1'b1; bus.i_RxData = 32'd78;
    @(negedge clk);
    bus.i_RxValid = 1'b0;
    check("irq_lag", {31'd0, bus.o_Irq}, 0);
    @(negedge clk);
    check("irq_rise", {31'd0, bus.o_Irq}, 1);
    cpu_read(32'd2, rd); check("irq_pop", rd, 77);
    check("irq_hold", {31'd0, bus.o_Irq}, 1);
    @(negedge clk);
    check("irq_fall", {31'd0, bus.o_Irq}, 0);
    cpu_read(32'd2, rd); check("irq_pop2", rd, 78);

    // RX full with simultaneous CPU pop
    cpu_write(32'd0, 32'd1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.i_RxValid = 1'b1; bus.i_RxData = 32'(200 + i);
    end
    @(negedge clk);
    bus.i_RxData = 32'd300;
    check("rx_full_ready", {31'd0, bus.o_RxReady}, 0);
    bus.i_REnable = 1'b1; bus.i_RAddr = 32'd2;
    @(negedge clk);
    bus.i_REnable = 1'b0;
    check("rx_full_pop", bus.o_RData, 200);
    check("rx_freed_ready", {31'd0, bus.o_RxReady}, 1);
    @(negedge clk);
    bus.i_RxValid = 1'b0;
    check("rx_refull_ready", {31'd0, bus.o_RxReady}, 0);
    cpu_read(32'd1, rd); check("rx_full_status", rd, 32'h0008_0009);

    // Flush
    cpu_write(32'd2, 32'd1);
    cpu_write(32'd2, 32'd2);
    check("pre_flush_valid", {31'd0, bus.o_TxValid}, 1);
    cpu_write(32'd0, 32'd3);
    check("flush_valid", {31'd0, bus.o_TxValid}, 0);
    cpu_read(32'd1, rd); check("flush_status", rd, 32'h0000_0005);
    cpu_read(32'd0, rd); check("flush_ctrl", rd, 32'd1);

    // Reset mid-operation
    cpu_write(32'd3, 32'hCAFE);
    cpu_write(32'd4, 32'd1);
    cpu_write(32'd0, 32'd5);
    cpu_write(32'd2, 32'd9);
    @(negedge clk);
    bus.i_RxValid = 1'b1; bus.i_RxData = 32'd55;
    @(negedge clk);
    bus.i_RxValid = 1'b0;
    @(negedge clk);
    check("pre_rst_irq", {31'd0, bus.o_Irq}, 1);
    bus.i_REnable = 1'b1; bus.i_RAddr = 32'd3; rst = 1'b1;
    @(negedge clk);
    bus.i_REnable = 1'b0; rst = 1'b0;
    check("mid_rst_rdata", bus.o_RData, 0);
    check("mid_rst_irq", {31'd0, bus.o_Irq}, 0);
    check("mid_rst_txvalid", {31'd0, bus.o_TxValid}, 0);
    check("mid_rst_txdata", bus.o_TxData, 0);
    check("mid_rst_rxready", {31'd0, bus.o_RxReady}, 0);
    cpu_read(32'd3, rd); check("mid_rst_scratch", rd, 0);
    cpu_read(32'd1, rd); check("mid_rst_status", rd, 32'h0000_0005);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
